// File: rtl/point_award_ctrl.sv
// Scoring front end: turns hit/miss events into one-cycle accumulate writes for the points register.
// Optional combo decay on inactivity is enabled by defining COMBO_TIMEOUT_EN.
module point_award_ctrl #(
    parameter int COMBO_STEP     = 4,
    parameter int MAX_SCORE      = 31,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       game_active,
    input  logic       hit,
    input  logic [2:0] hit_value,
    input  logic       miss,
    output logic       write,
    output logic       Addr,
    output logic [4:0] WrData,
    output logic [3:0] combo,
    output logic [2:0] mult,
    output logic [4:0] total,
    output logic       maxed
);

    localparam logic [4:0] MAX_SCORE_W = 5'(MAX_SCORE);
    localparam logic [3:0] COMBO_SAT   = 4'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        MAXED = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       write_q, write_d;
    logic [4:0] wr_data_q, wr_data_d;
    logic [3:0] combo_q, combo_d;
    logic [2:0] mult_q, mult_d;
    logic [4:0] total_q, total_d;
    logic       maxed_q, maxed_d;

    logic [5:0] raw;
    logic [4:0] headroom;
    logic [4:0] award;

    function automatic logic [2:0] mult_for(input logic [3:0] c);
        int lvl;
        lvl = int'(c) / COMBO_STEP;
        if (lvl > 3) begin
            lvl = 3;
        end
        return 3'(lvl + 1);
    endfunction

    // Award is clipped to the remaining headroom so the wrapping downstream accumulator never overflows.
    always_comb begin
        raw      = {3'b000, hit_value} * {3'b000, mult_q};
        headroom = MAX_SCORE_W - total_q;
        award    = (raw > {1'b0, headroom}) ? headroom : raw[4:0];
    end

`ifdef COMBO_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 10) ? $clog2(TIMEOUT_CYCLES + 1) : 10;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
`endif

    always_comb begin
        state_d   = state_q;
        write_d   = 1'b0;
        wr_data_d = 5'd0;
        combo_d   = combo_q;
        total_d   = total_q;
`ifdef COMBO_TIMEOUT_EN
        idle_cnt_d = '0;
`endif

        case (state_q)
            IDLE: begin
                if (game_active) begin
                    state_d = PLAY;
                end
            end

            PLAY: begin
                if (hit) begin
                    if (award != 5'd0) begin
                        write_d   = 1'b1;
                        wr_data_d = award;
                        total_d   = total_q + award;
                    end
                    if (combo_q != COMBO_SAT) begin
                        combo_d = combo_q + 4'd1;
                    end
                end
                // Miss wins over a simultaneous hit for the streak; the award already used the old multiplier.
                if (miss) begin
                    combo_d = 4'd0;
                end
`ifdef COMBO_TIMEOUT_EN
                if (hit || miss) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == CNT_LAST) begin
                    combo_d    = 4'd0;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
`endif
                if (!game_active) begin
                    combo_d = 4'd0;
                    state_d = IDLE;
`ifdef COMBO_TIMEOUT_EN
                    idle_cnt_d = '0;
`endif
                end
                // Reaching the ceiling is terminal until reset, even if the round ends on the same cycle.
                if (total_d == MAX_SCORE_W) begin
                    state_d = MAXED;
`ifdef COMBO_TIMEOUT_EN
                    idle_cnt_d = '0;
`endif
                end
            end

            MAXED: begin
                state_d = MAXED;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        mult_d  = mult_for(combo_d);
        maxed_d = (state_d == MAXED);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q   <= IDLE;
            write_q   <= 1'b0;
            wr_data_q <= 5'd0;
            combo_q   <= 4'd0;
            mult_q    <= 3'd1;
            total_q   <= 5'd0;
            maxed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            wr_data_q <= wr_data_d;
            combo_q   <= combo_d;
            mult_q    <= mult_d;
            total_q   <= total_d;
            maxed_q   <= maxed_d;
        end
    end

`ifdef COMBO_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (rst) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`endif

    assign write  = write_q;
    assign Addr   = 1'b1;
    assign WrData = wr_data_q;
    assign combo  = combo_q;
    assign mult   = mult_q;
    assign total  = total_q;
    assign maxed  = maxed_q;

endmodule

// File: doc/point_award_ctrl.md
Name: point_award_ctrl

Overview:
- Upstream scoring stage for the points register. Converts game hit/miss events into single-cycle accumulate writes (write, Addr, WrData) that the register adds to its points entry.
- Tracks a combo streak to scale awards by a multiplier.
- Keeps a shadow running total so that awards never push the 5-bit downstream accumulator past MAX_SCORE, because that accumulator wraps.

Parameters:
- COMBO_STEP, 4, consecutive hits needed per multiplier level.
- MAX_SCORE, 31, ceiling for the cumulative awarded points (≤31).
- TIMEOUT_CYCLES, 1000, cycles without a hit before the combo decays (COMBO_TIMEOUT_EN only).

Ports:
- clock  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- game_active  in  1  high while a round is in play.
- hit  in  1  one-cycle hit event.
- hit_value  in  3  base points for this hit, sampled with hit.
- miss  in  1  one-cycle miss event.
- write  out  1  one-cycle accumulate strobe to the points register.
- Addr  out  1  register address; constant 1'b1 (the points entry).
- WrData  out  5  points to add.
- combo  out  4  current streak, saturates at 15.
- mult  out  3  current multiplier, 1..4.
- total  out  5  shadow of cumulative awarded points.
- maxed  out  1  high once total == MAX_SCORE.

Behaviour:
- Reset: clock is clock; rst is synchronous and active-high. On reset: write=0, WrData=0, Addr=1, combo=0, mult=1, total=0, maxed=0, state=IDLE. rst overrides every same-cycle event, and no write is issued for a hit sampled at a reset edge.
- States:
  - IDLE: hit and miss are ignored. game_active=1 → PLAY.
  - PLAY: hits and misses are processed as below.
  - MAXED: hits and misses are ignored, write stays 0, maxed=1. Leaves MAXED only on rst.
- PLAY → IDLE when game_active=0: combo is cleared to 0 and mult to 1; total is retained, because the downstream register clears only on rst.
- Multiplier: mult = 1 + min(combo / COMBO_STEP, 3). It is registered and always consistent with the registered combo.
- Hit in PLAY:
  - raw = hit_value * mult, 5-bit result, maximum 28.
  - award = min(raw, MAX_SCORE - total).
  - If award > 0: on the next cycle write=1 and WrData=award, and total updates on the same edge.
  - combo = min(combo+1, 15), with mult updated accordingly.
  - hit_value=0 still counts toward combo but issues no write.
- Latency: exactly 1 cycle from the hit sample to the write strobe. Back-to-back hits on every cycle produce a write on every cycle; no buffering is needed.
- write is high for exactly one cycle per awarded hit. WrData = 0 whenever write = 0.
- Miss in PLAY: combo → 0, mult → 1, no write.
- Hit and miss in the same cycle: the award uses the pre-miss mult, then combo → 0.
- When total reaches MAX_SCORE (on the write edge): state → MAXED and maxed=1 on that same edge.
- game_active falls in the cycle after a hit: the already-registered write is still issued.

Optional Feature:
- COMBO_TIMEOUT_EN defined:
  - A 10-bit (or wider) idle counter runs in PLAY.
  - It clears on a hit, a miss, or entry into PLAY.
  - When it reaches TIMEOUT_CYCLES: combo → 0, mult → 1, counter clears.
  - The counter is held at 0 in IDLE and MAXED.
- COMBO_TIMEOUT_EN undefined: no counter. combo is cleared only by miss, game_active fall, or rst.

Test Plan:
- Basic award: rst, game_active=1, one hit with hit_value=3 → next cycle write=1, WrData=3, Addr=1; total=3, combo=1, mult=1; the following cycle write=0.
- Combo scaling: five back-to-back hits with hit_value=2, COMBO_STEP=4 → WrData sequence 2,2,2,2,4 on consecutive cycles; combo=5, mult=2, total=12.
- Saturation: preload total=28 via hits, then hit with hit_value=7 at mult=1 → WrData=3, total=31, maxed=1, state MAXED; a further hit → write stays 0.
- Simultaneous events: combo=8 (mult=3), hit with hit_value=5 plus miss in the same cycle → WrData=15; combo=0, mult=1 afterwards.
- Timeout: TIMEOUT_CYCLES=10, combo=4, no events for 10 cycles → with COMBO_TIMEOUT_EN, combo=0 and mult=1; without it, combo stays 4 and mult stays 2.
- Reset priority: hit with hit_value=6 sampled in the same cycle as rst=1 → next cycle write=0, total=0, combo=0. Also, game_active dropping mid-streak → combo=0 and total unchanged.
